// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Round-robin arbiter that shares the ROB's single execute-result write port
//   among N_REQ result producers (default: 0 = ALU, 1 = branch unit,
//   2 = address unit). One winner per cycle is registered onto the common data
//   bus (CDB), which feeds the ROB ex-result inputs and RS wakeup.
//
// Ports
//   clk_in        clock
//   rst_in        synchronous, active-high reset (overrides rdy_in/flush_in)
//   rdy_in        global enable; 0 freezes all state and blocks grants
//   flush_in      ROB control hazard; blocks grants, drops CDB, rr pointer -> 0
//   req_valid     per-requester offer
//   req_ready     per-requester accept (combinational, one-hot or zero)
//   req_rob_pos   packed target ROB slots, requester i at [i*Q_WIDTH +: Q_WIDTH]
//   req_value     packed result values,   requester i at [i*32 +: 32]
//   req_pc        packed next PCs,        requester i at [i*32 +: 32]
//   cdb_valid     CDB carries a result
//   cdb_rob_pos   CDB target ROB slot
//   cdb_value     CDB result value
//   cdb_pc        CDB resolved next PC
//   cdb_src       index of the requester that produced the CDB entry
//   conflict_cnt  cycles with >= 2 requesters competing (CDB_ARB_PERF_EN only)
//
// Configuration
//   CDB_ARB_PERF_EN  when defined, adds the conflict_cnt port and its counter.
// -----------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int N_REQ   = 3,
   parameter int Q_WIDTH = 4,
   parameter int SRC_W   = 2
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     rdy_in,
   input  logic                     flush_in,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ*Q_WIDTH-1:0] req_rob_pos,
   input  logic [N_REQ*32-1:0]      req_value,
   input  logic [N_REQ*32-1:0]      req_pc,
   output logic                     cdb_valid,
   output logic [Q_WIDTH-1:0]       cdb_rob_pos,
   output logic [31:0]              cdb_value,
   output logic [31:0]              cdb_pc,
   output logic [SRC_W-1:0]         cdb_src
`ifdef CDB_ARB_PERF_EN
   ,
   output logic [31:0]              conflict_cnt
`endif
);

   logic               cdb_valid_r;
   logic [Q_WIDTH-1:0] cdb_rob_pos_r;
   logic [31:0]        cdb_value_r;
   logic [31:0]        cdb_pc_r;
   logic [SRC_W-1:0]   cdb_src_r;
   logic [SRC_W-1:0]   rr_ptr_r;

   logic               grant_en_s;
   logic               found_s;
   logic [N_REQ-1:0]   grant_s;
   logic [SRC_W-1:0]   win_idx_s;
   logic [SRC_W-1:0]   rr_next_s;
   logic [Q_WIDTH-1:0] sel_pos_s;
   logic [31:0]        sel_value_s;
   logic [31:0]        sel_pc_s;

   // Grants are only possible in a live, non-flushed, non-reset cycle.
   assign grant_en_s = rdy_in & ~flush_in & ~rst_in;

   // Round-robin scan starting at rr_ptr; first valid requester wins and its payload is selected.
   always_comb begin
      found_s     = 1'b0;
      grant_s     = '0;
      win_idx_s   = '0;
      sel_pos_s   = '0;
      sel_value_s = 32'h0000_0000;
      sel_pc_s    = 32'h0000_0000;
      if (grant_en_s) begin
         for (int k = 0; k < N_REQ; k++) begin
            automatic int idx = (int'(rr_ptr_r) + k) % N_REQ;
            if (!found_s && req_valid[idx]) begin
               found_s      = 1'b1;
               grant_s[idx] = 1'b1;
               win_idx_s    = SRC_W'(idx);
               sel_pos_s    = req_rob_pos[idx*Q_WIDTH +: Q_WIDTH];
               sel_value_s  = req_value[idx*32 +: 32];
               sel_pc_s     = req_pc[idx*32 +: 32];
            end else begin
               found_s = found_s;
            end
         end
      end else begin
         found_s = 1'b0;
      end
   end

   // Pointer moves one past the winner, wrapping at the last requester.
   always_comb begin
      rr_next_s = '0;
      if (win_idx_s == SRC_W'(N_REQ - 1)) begin
         rr_next_s = '0;
      end else begin
         rr_next_s = win_idx_s + SRC_W'(1);
      end
   end

   assign req_ready = grant_s;

   // CDB register and round-robin pointer; rdy_in=0 holds everything, including a pending CDB entry.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cdb_valid_r   <= 1'b0;
         cdb_rob_pos_r <= '0;
         cdb_value_r   <= 32'h0000_0000;
         cdb_pc_r      <= 32'h0000_0000;
         cdb_src_r     <= '0;
         rr_ptr_r      <= '0;
      end else if (!rdy_in) begin
         cdb_valid_r   <= cdb_valid_r;
      end else if (flush_in) begin
         cdb_valid_r   <= 1'b0;
         rr_ptr_r      <= '0;
      end else if (found_s) begin
         cdb_valid_r   <= 1'b1;
         cdb_rob_pos_r <= sel_pos_s;
         cdb_value_r   <= sel_value_s;
         cdb_pc_r      <= sel_pc_s;
         cdb_src_r     <= win_idx_s;
         rr_ptr_r      <= rr_next_s;
      end else begin
         // Idle cycle: drop valid, data fields keep their last (don't-care) value.
         cdb_valid_r   <= 1'b0;
      end
   end

   assign cdb_valid   = cdb_valid_r;
   assign cdb_rob_pos = cdb_rob_pos_r;
   assign cdb_value   = cdb_value_r;
   assign cdb_pc      = cdb_pc_r;
   assign cdb_src     = cdb_src_r;

`ifdef CDB_ARB_PERF_EN
   logic [31:0] conflict_cnt_r;

   function automatic int unsigned count_ones(input logic [N_REQ-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < N_REQ; i++) begin
         n = n + int'(v[i]);
      end
      return n;
   endfunction

   // Counts live cycles with two or more competing requesters; wraps naturally, survives flush.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         conflict_cnt_r <= 32'h0000_0000;
      end else if (rdy_in && !flush_in && (count_ones(req_valid) >= 2)) begin
         conflict_cnt_r <= conflict_cnt_r + 32'h0000_0001;
      end else begin
         conflict_cnt_r <= conflict_cnt_r;
      end
   end

   assign conflict_cnt = conflict_cnt_r;
`endif

endmodule
